pila_lifo: RTL
==============

# pila_lifo

Parameterised LIFO stack: the read-back counterpart of the enable-gated storage register. The producer pushes N-bit words; the consumer pops them in reverse order and gets a one-cycle `letto` pulse with the removed word. It exposes the current top of stack, occupancy, full/empty flags and a sticky error flag. It is the storage core of the stack unit, sitting between the operand datapath and the control sequencer.

## Interface
- `N`, 32, data width in bits (≥1)
- `DEPTH`, 8, number of entries (power of two, ≥2)
- `CW`, derived `$clog2(DEPTH+1)`, width of `count`

- `clock`  input  1  rising-edge clock, sole clock of the block
- `reset_n`  input  1  asynchronous, active-low reset
- `clear`  input  1  synchronous empty-the-stack request; dominates `push`/`pop`
- `push`  input  1  write `in` on top this cycle
- `pop`  input  1  remove top entry this cycle
- `in`  input  N  data to push
- `out`  output  N  current top of stack (registered); 0 when empty
- `dato_letto`  output  N  word removed by the last successful pop (registered)
- `letto`  output  1  one-cycle pulse: `dato_letto` updated this cycle
- `count`  output  CW  number of stored entries, 0..DEPTH
- `empty`  output  1  `count == 0`
- `full`  output  1  `count == DEPTH`
- `errore`  output  1  sticky overflow/underflow flag

## Operation
- Storage: DEPTH×N register array plus a stack pointer (= `count`); array contents are not reset.
- Command decode per rising edge (priority top-down):
  - `clear`: count←0, out←0, errore←0, letto←0; `dato_letto` held.
  - `push & pop`, not empty: replace top. mem[count-1]←in, out←in, count unchanged. letto←1, dato_letto←old top.
  - `push & pop`, empty: behaves as plain push. No error, letto←0.
  - `push` only, not full: mem[count]←in, count←count+1, out←in, letto←0.
  - `push` only, full: ignored. errore←1, state unchanged.
  - `pop` only, not empty: dato_letto←old top, letto←1, count←count-1. out←mem[count-2], or 0 if count becomes 0.
  - `pop` only, empty: ignored. errore←1, letto←0.
  - Idle: letto←0, all else held.
- `errore` is sticky. Only `clear` or `reset_n` low clears it.
- `empty`/`full` are decoded from the registered `count`, so they change in the same cycle as `count`.
- No arithmetic on data. Pointer arithmetic is modulo-free and never leaves 0..DEPTH because of the guards above.

## Timing
- All outputs are registers updated on the rising `clock` edge. Latency from command to visible result is 1 cycle.
- A push in cycle k makes `out` = `in` after edge k. A pop in cycle k+1 gives `letto`=1 and `dato_letto`=that word after edge k+1.
- `letto` is high for exactly one cycle per successful pop or replace. Back-to-back pops give consecutive pulses.
- Reset values, applied asynchronously on `reset_n` falling and held while low: out=0, dato_letto=0, letto=0, count=0, empty=1, full=0, errore=0.
- Reset mid-operation aborts any in-flight command. The first edge after `reset_n` rises executes normally.
- Inputs are sampled only at rising edges and must be stable around them. No combinational input→output paths.

## Test plan
1. Reset then idle (N=32, DEPTH=4): assert `reset_n`=0 mid-cycle → out=0, count=0, empty=1, full=0, errore=0, letto=0 immediately, without waiting for a clock edge.
2. Fill and drain: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Check out=0x44, count=4, full=1. Then pop four times. Check `dato_letto` pulses 0x44, 0x33, 0x22, 0x11 with letto=1 each cycle, and after the last pop out=0, empty=1, errore=0.
3. Overflow/underflow: with the stack full, push 0x55 → count stays 4, out=0x44, errore=1. Then `clear` → count=0, errore=0. Then pop → errore=1, letto=0.
4. Simultaneous push+pop: with the stack holding 0xA, 0xB, drive push=pop=1 with in=0xC → out=0xC, count=2, letto=1, dato_letto=0xB. On an empty stack, push+pop with 0xD → out=0xD, count=1, letto=0, errore=0.
5. Clear priority: clear=push=pop=1 on a stack holding 3 entries → count=0, out=0, letto=0, and `dato_letto` is unchanged.
6. Reset mid-burst: during alternating push/pop traffic, pulse `reset_n` low for 3 ns between edges → all outputs return to reset values at once. The next push of 0x7 gives out=0x7, count=1.

Source files
------------

// File: rtl/pila_lifo.sv
// Parameterised LIFO stack with registered top-of-stack, pop read-back pulse
// and sticky overflow/underflow flag.
module pila_lifo #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [N-1:0]  in,
    output logic [N-1:0]  out,
    output logic [N-1:0]  dato_letto,
    output logic          letto,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          errore
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt_m1;
    logic [CW-1:0] cnt_m2;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] below_idx;
    logic          do_replace;
    logic          do_push;
    logic          do_pop;
    logic          bad_op;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);

    assign cnt_m1    = count - CW'(1);
    assign cnt_m2    = count - CW'(2);
    assign top_idx   = cnt_m1[AW-1:0];
    assign wr_idx    = count[AW-1:0];
    assign below_idx = cnt_m2[AW-1:0];

    // Push together with pop on an empty stack degrades to a plain push.
    assign do_replace = !clear && push && pop && !empty;
    assign do_push    = !clear && push && !(pop && !empty) && !full;
    assign do_pop     = !clear && pop && !push && !empty;
    assign bad_op     = !clear && ((push && !pop && full) || (pop && !push && empty));

    // Storage array is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (do_replace) begin
            mem[top_idx] <= in;
        end else if (do_push) begin
            mem[wr_idx] <= in;
        end
    end

    // The out register always mirrors mem[count-1], so it doubles as the popped word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out        <= '0;
            dato_letto <= '0;
            letto      <= 1'b0;
            count      <= '0;
            errore     <= 1'b0;
        end else begin
            letto <= do_replace || do_pop;
            if (clear) begin
                count  <= '0;
                out    <= '0;
                errore <= 1'b0;
            end else begin
                if (bad_op) begin
                    errore <= 1'b1;
                end
                if (do_replace) begin
                    out        <= in;
                    dato_letto <= out;
                end else if (do_push) begin
                    out   <= in;
                    count <= count + CW'(1);
                end else if (do_pop) begin
                    dato_letto <= out;
                    count      <= cnt_m1;
                    out        <= (cnt_m1 == '0) ? '0 : mem[below_idx];
                end
            end
        end
    end

endmodule
